alu_issue_sequencer: RTL

//  Shares the single combinational 32-bit ALU (ops A_in,B_in,opcode,carry -> result,N,Z,V,C)

---
 rtl/alu_issue_sequencer_pkg.sv | 25 ++
 rtl/alu_issue_sequencer_if.sv | 29 ++
 rtl/alu_issue_sequencer_rr_arb2.sv | 34 +++
 rtl/alu_issue_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_issue_sequencer_pkg.sv
// Shared types and constants for the ALU issue sequencer slice.
package alu_issue_sequencer_pkg;

  localparam int NREQ     = 2;
  localparam int OPW      = 6;
  localparam int OP_S_BIT = 4;  // opcode bit requesting a PSR update
  localparam int OP_X_BIT = 3;  // opcode bit selecting PSR.C as carry-in

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Carry-in for the shared ALU: only carry-using opcodes see PSR.C.
  function automatic logic carry_in(input logic [OPW-1:0] op, input logic [3:0] nzvc);
    return op[OP_X_BIT] ? nzvc[FLG_C] : 1'b0;
  endfunction

endpackage

// File: rtl/alu_issue_sequencer_if.sv
// Requester and response handshake bundle for the ALU issue sequencer.
interface alu_issue_sequencer_if #(
  parameter int DW = 32
);
  import alu_issue_sequencer_pkg::*;

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DW-1:0]  req_a;
  logic [NREQ*DW-1:0]  req_b;
  logic [NREQ*OPW-1:0] req_op;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [DW-1:0]       rsp_result;

  // Requester/consumer side.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );

endinterface

// File: rtl/alu_issue_sequencer_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past whoever was granted.
module alu_issue_sequencer_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio_q;  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic prio_d;

  // Lone requester always wins; ties resolved by the pointer.
  always_comb begin
    gnt    = req;
    prio_d = prio_q;
    if (req == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
    if (advance && (gnt != 2'b00)) begin
      prio_d = gnt[0];
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Shares one combinational ALU between two requesters and owns the PSR flags.
module alu_issue_sequencer
  import alu_issue_sequencer_pkg::*;
#(
  parameter int DW      = 32,
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_issue_sequencer_if.slave  bus,
  output logic [DW-1:0]         alu_a,
  output logic [DW-1:0]         alu_b,
  output logic [OPW-1:0]        alu_op,
  output logic                  alu_cin,
  input  logic [DW-1:0]         alu_result,
  input  logic                  alu_n,
  input  logic                  alu_z,
  input  logic                  alu_v,
  input  logic                  alu_c,
  input  logic                  psr_we,
  input  logic [3:0]            psr_wdata,
  output logic [3:0]            psr_nzvc,
  output logic                  busy
);

  if ((ALU_LAT < 1) || (ALU_LAT > 15)) begin : g_bad_lat
    $error("alu_issue_sequencer: ALU_LAT must be within 1..15");
  end
  if (DW != 32) begin : g_bad_dw
    $error("alu_issue_sequencer: only a 32-bit datapath is supported");
  end

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [DW-1:0]  a_q, b_q, result_q;
  logic [OPW-1:0] op_q;
  logic           cin_q, id_q;
  logic [3:0]     psr_q;
  logic [3:0]     alu_flags;
  logic [1:0]     gnt;
  logic           gnt_id;
  logic           take, capture;

  logic [DW-1:0]  a_arr  [NREQ];
  logic [DW-1:0]  b_arr  [NREQ];
  logic [OPW-1:0] op_arr [NREQ];

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]  = bus.req_a[gi*DW +: DW];
    assign b_arr[gi]  = bus.req_b[gi*DW +: DW];
    assign op_arr[gi] = bus.req_op[gi*OPW +: OPW];
  end

  assign gnt_id = gnt[1];

  alu_issue_sequencer_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .advance (take),
    .gnt     (gnt)
  );

  // Next-state logic: accept in IDLE, count down in EXEC, wait for consumer in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          take    = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand latch at grant; carry-in frozen here so later PSR writes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cin_q <= 1'b0;
      id_q  <= 1'b0;
    end else if (take) begin
      a_q   <= a_arr[gnt_id];
      b_q   <= b_arr[gnt_id];
      op_q  <= op_arr[gnt_id];
      cin_q <= carry_in(op_arr[gnt_id], psr_q);
      id_q  <= gnt_id;
    end
  end

  // Result capture at the end of the hold window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else if (capture) begin
      result_q <= alu_result;
    end
  end

  always_comb begin
    alu_flags        = 4'b0000;
    alu_flags[FLG_N] = alu_n;
    alu_flags[FLG_Z] = alu_z;
    alu_flags[FLG_V] = alu_v;
    alu_flags[FLG_C] = alu_c;
  end

  // PSR: S-bit capture beats a coincident software write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psr_q <= 4'b0000;
    end else if (capture && op_q[OP_S_BIT]) begin
      psr_q <= alu_flags;
    end else if (psr_we) begin
      psr_q <= psr_wdata;
    end
  end

  // Grants only in IDLE and never while reset is asserted.
  assign bus.req_ready  = ((state_q == ST_IDLE) && rst_n) ? gnt : 2'b00;
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_op         = op_q;
  assign alu_cin        = cin_q;
  assign psr_nzvc       = psr_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
